sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single external 512K x16 asynchronous SRAM between two on-chip requesters: A, the motor-profile table loader, and B, the trajectory logger.
- Sequences every SRAM cycle (CE_N/OE_N/WE_N/BE_N/address/data) with programmable strobe width.
- Sits between the requesters and the top-level sram_SRAM_* pins. It replaces direct single-master SRAM access.

Parameters:
- WAIT_CYCLES, 2, strobe width in clocks (legal 1..15; 4-bit counter).
- ADDR_W, 19, SRAM word address width.
- DATA_W, 16, SRAM data width.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous, active-low reset
- a_req  in  1  requester A access request, held until a_ack
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  19  A word address
- a_wdata  in  16  A write data
- a_be  in  2  A byte enables, active-high
- a_ack  out  1  A completion pulse, 1 cycle
- a_rdata  out  16  A read data, valid when a_ack=1 and a_we=0
- b_req, b_we, b_addr, b_wdata, b_be, b_ack, b_rdata: same as A, for requester B
- busy  out  1  high in any state other than IDLE
- sram_SRAM_A  out  19  SRAM address
- sram_SRAM_D  inout  16  SRAM data bus
- sram_SRAM_BE_N  out  2  byte enables, active-low
- sram_SRAM_CE_N  out  1  chip enable, active-low
- sram_SRAM_OE_N  out  1  output enable, active-low
- sram_SRAM_WE_N  out  1  write enable, active-low

Behaviour:
- Reset (asynchronous, any state):
  - CE_N=1, OE_N=1, WE_N=1, BE_N=2'b11, A=0, D=high-Z.
  - a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0.
  - State=IDLE, counter=0, last-grant=B.
- Requests and commands are sampled only in IDLE. The grantee's we/addr/wdata/be are latched at grant. Later changes are ignored until its ack.
- FSM:
  - IDLE: when any req is high, select the grantee, latch its command and go to SETUP.
  - SETUP (1 cycle):
    - CE_N=0, A=latched addr, BE_N=~be.
    - Write: D driven with wdata. Read: D high-Z.
    - WE_N=1, OE_N=1.
  - STROBE (WAIT_CYCLES cycles, counter counts down from WAIT_CYCLES-1 to 0):
    - Write: WE_N=0. Read: OE_N=0.
  - DONE (1 cycle):
    - WE_N=1, OE_N=1, CE_N=0, address and write data held (hold time).
    - Read: sram_SRAM_D is registered into the grantee's rdata on the STROBE->DONE edge.
    - Grantee's ack=1 for this cycle only.
  - TURN (1 cycle): CE_N=1, D=high-Z, BE_N=11, then IDLE.
- Latency: req seen in IDLE -> ack asserted WAIT_CYCLES+2 clocks later. Throughput is one access per WAIT_CYCLES+4 clocks.
- The bus is never driven while OE_N=0. The D output-enable is asserted only in SETUP, STROBE and DONE of a write.
- Requester holding req after its ack: treated as a new request at the next IDLE.
- Requester dropping req before ack: protocol violation. The access still completes and the ack is still pulsed.
- rdata holds its value until that requester's next read completes. Writes do not change rdata.
- Simultaneous a_req and b_req in IDLE: resolved by the priority rule (see Optional Feature).
- WAIT_CYCLES=0 is illegal. A generate check forces an elaboration error.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin. On a conflict, the requester not granted last wins.
  - last-grant updates on every grant.
  - No requester waits more than one access.
- Undefined:
  - Fixed priority, A always wins a conflict.
  - B may starve under back-to-back A requests. This is accepted for the loader use case.
  - last-grant register not implemented.

Test Plan:
- Reset mid-STROBE of an A write -> same cycle, WE_N=1, CE_N=1, D=Z, a_ack never pulses, busy=0.
- A write, addr=0x1234, wdata=0xBEEF, be=11, WAIT_CYCLES=2:
  - WE_N low exactly 2 cycles, D=0xBEEF throughout SETUP..DONE.
  - a_ack at cycle 4 after req.
  - Read back 0x1234 -> a_rdata=0xBEEF.
- B read with be=01, SRAM model returning 0xA55A:
  - BE_N=10, OE_N low 2 cycles, D never driven by DUT.
  - b_rdata=0xA55A with b_ack.
- a_req and b_req held continuously, 4 accesses:
  - Macro undefined: grants A,A,A,A.
  - Macro defined: grants A,B,A,B (last-grant resets to B).
- WAIT_CYCLES=15, a_addr changed during STROBE -> sram_SRAM_A keeps the latched address, ack at cycle 17.
- b_req dropped in SETUP -> access completes, b_ack pulses once, FSM returns to IDLE after TURN.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter and cycle sequencer for the external
// 512K x16 asynchronous SRAM. Requester A is the motor-profile table loader,
// requester B the trajectory logger.
//
// Each access runs IDLE -> SETUP -> STROBE (WAIT_CYCLES clocks) -> DONE -> TURN.
// All SRAM pins are registered.
//
// Optional build macro SRAM_ARB_ROUND_ROBIN_EN selects the arbitration policy:
//   defined   : round-robin on conflicts, using a last-grant register that
//               resets to B.
//   undefined : fixed priority, A always wins a conflict (B may starve).
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [1:0]        a_be,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [1:0]        b_be,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,

    output logic              busy,

    output logic [ADDR_W-1:0] sram_SRAM_A,
    inout  wire  [DATA_W-1:0] sram_SRAM_D,
    output logic [1:0]        sram_SRAM_BE_N,
    output logic              sram_SRAM_CE_N,
    output logic              sram_SRAM_OE_N,
    output logic              sram_SRAM_WE_N
);

    // The strobe counter is 4 bits wide, so only 1..15 clocks can be encoded.
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_cycles_check
        $error("sram_arbiter: WAIT_CYCLES must be in the range 1..15");
    end

    localparam logic [3:0] STROBE_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        DONE   = 3'd3,
        TURN   = 3'd4
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                gnt_b;     // current access belongs to B
    logic                cmd_we;    // latched write/read of current access
    logic [DATA_W-1:0]   d_out;     // latched write data
    logic                d_oe;      // drive the data bus (writes only)
    logic                grant_b;   // arbitration result, used in IDLE only

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic                last_b;    // last grant went to B

    // Round-robin: on a conflict the requester not granted last wins.
    always_comb begin
        grant_b = b_req && (!a_req || !last_b);
    end

    // Last-grant register, updated on every grant.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            last_b <= 1'b1;
        end else if (state == IDLE && (a_req || b_req)) begin
            last_b <= grant_b;
        end
    end
`else
    // Fixed priority: B is granted only when A is not requesting.
    always_comb begin
        grant_b = b_req && !a_req;
    end
`endif

    // The data bus is driven only from SETUP through DONE of a write.
    assign sram_SRAM_D = d_oe ? d_out : {DATA_W{1'bz}};

    // Access sequencer: grant, latch the command, and walk the SRAM cycle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            gnt_b          <= 1'b0;
            cmd_we         <= 1'b0;
            d_out          <= '0;
            d_oe           <= 1'b0;
            busy           <= 1'b0;
            a_ack          <= 1'b0;
            b_ack          <= 1'b0;
            a_rdata        <= '0;
            b_rdata        <= '0;
            sram_SRAM_A    <= '0;
            sram_SRAM_BE_N <= 2'b11;
            sram_SRAM_CE_N <= 1'b1;
            sram_SRAM_OE_N <= 1'b1;
            sram_SRAM_WE_N <= 1'b1;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state          <= SETUP;
                        busy           <= 1'b1;
                        gnt_b          <= grant_b;
                        cmd_we         <= grant_b ? b_we : a_we;
                        d_oe           <= grant_b ? b_we : a_we;
                        d_out          <= grant_b ? b_wdata : a_wdata;
                        sram_SRAM_A    <= grant_b ? b_addr : a_addr;
                        sram_SRAM_BE_N <= grant_b ? ~b_be : ~a_be;
                        sram_SRAM_CE_N <= 1'b0;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    cnt   <= STROBE_LAST;
                    if (cmd_we) begin
                        sram_SRAM_WE_N <= 1'b0;
                    end else begin
                        sram_SRAM_OE_N <= 1'b0;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        state          <= DONE;
                        sram_SRAM_WE_N <= 1'b1;
                        sram_SRAM_OE_N <= 1'b1;
                        if (gnt_b) begin
                            b_ack <= 1'b1;
                        end else begin
                            a_ack <= 1'b1;
                        end
                        // Read data is still valid on this edge: OE_N is only
                        // released by it.
                        if (!cmd_we) begin
                            if (gnt_b) begin
                                b_rdata <= sram_SRAM_D;
                            end else begin
                                a_rdata <= sram_SRAM_D;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state          <= TURN;
                    sram_SRAM_CE_N <= 1'b1;
                    sram_SRAM_BE_N <= 2'b11;
                    d_oe           <= 1'b0;
                end
                TURN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter.
// Two instances are used: WAIT_CYCLES=2 with an SRAM model attached, and
// WAIT_CYCLES=15 for the long-strobe / address-hold scenario.
module tb_sram_arbiter;

    localparam int W   = 2;
    localparam int W15 = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance with WAIT_CYCLES = 2
    logic        a_req, a_we, b_req, b_we;
    logic [18:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [1:0]  a_be, b_be;
    logic        a_ack, b_ack, busy;
    logic [15:0] a_rdata, b_rdata;
    logic [18:0] s_a;
    wire  [15:0] s_d;
    logic [1:0]  s_be_n;
    logic        s_ce_n, s_oe_n, s_we_n;

    // Instance with WAIT_CYCLES = 15 (B side tied off)
    logic        x_req, x_we;
    logic [18:0] x_addr;
    logic [15:0] x_wdata;
    logic [1:0]  x_be;
    logic        x_ack, y_ack, x_busy;
    logic [15:0] x_rdata, y_rdata;
    logic [18:0] x_sa;
    wire  [15:0] x_sd;
    logic [1:0]  x_be_n;
    logic        x_ce_n, x_oe_n, x_we_n;

    int checks = 0;
    int fails  = 0;

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(19), .DATA_W(16)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy),
        .sram_SRAM_A(s_a), .sram_SRAM_D(s_d), .sram_SRAM_BE_N(s_be_n),
        .sram_SRAM_CE_N(s_ce_n), .sram_SRAM_OE_N(s_oe_n), .sram_SRAM_WE_N(s_we_n)
    );

    sram_arbiter #(.WAIT_CYCLES(W15), .ADDR_W(19), .DATA_W(16)) dut15 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .a_req(x_req), .a_we(x_we), .a_addr(x_addr), .a_wdata(x_wdata), .a_be(x_be),
        .a_ack(x_ack), .a_rdata(x_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(19'h0), .b_wdata(16'h0), .b_be(2'b00),
        .b_ack(y_ack), .b_rdata(y_rdata),
        .busy(x_busy),
        .sram_SRAM_A(x_sa), .sram_SRAM_D(x_sd), .sram_SRAM_BE_N(x_be_n),
        .sram_SRAM_CE_N(x_ce_n), .sram_SRAM_OE_N(x_oe_n), .sram_SRAM_WE_N(x_we_n)
    );

    // ---------------- SRAM device model (4K words, address bits [11:0]) ----
    logic [15:0] sram_mem [0:4095];
    logic [15:0] sram_q;
    logic        mem_clear, preload_en;
    logic [11:0] preload_idx;
    logic [15:0] preload_val;

    function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] be);
        return {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) sram_mem[i] <= 16'h0;
        end else if (preload_en) begin
            sram_mem[preload_idx] <= preload_val;
        end else if (!s_ce_n && !s_we_n) begin
            sram_mem[s_a[11:0]] <= merge(sram_mem[s_a[11:0]], s_d, ~s_be_n);
        end
    end

    always @(negedge clk) sram_q <= sram_mem[s_a[11:0]];

    assign s_d = (!s_ce_n && !s_oe_n) ? sram_q : 16'hzzzz;

    // ---------------- Reference model state -------------------------------
    logic [15:0] ref_mem [0:7];      // contents of words 0x100..0x107
    logic [15:0] ref_rdata [0:1];    // expected rdata per requester (0=A,1=B)

    // ---------------- Per-access observations -----------------------------
    int          o_ack_cycle, o_acks, o_other, o_we_low, o_oe_low;
    int          o_a_bad, o_be_bad, o_d_bad;
    logic        o_busy_after;
    logic [15:0] o_rdata;

    // Issues one access from A or B on the WAIT_CYCLES=2 instance and records
    // what the SRAM pins and handshake did. Command inputs are scrambled after
    // grant to show they are latched. drop_at>0 drops req at that cycle.
    task automatic run_access(input bit is_b, input bit we, input logic [18:0] addr,
                              input logic [15:0] wdata, input logic [1:0] be, input int drop_at);
        int n;
        bit done;
        logic my_ack, oth_ack;
        n = 0; done = 0;
        o_ack_cycle = -1; o_acks = 0; o_other = 0; o_we_low = 0; o_oe_low = 0;
        o_a_bad = 0; o_be_bad = 0; o_d_bad = 0; o_busy_after = 1'bx; o_rdata = 16'hxxxx;
        if (is_b) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_be = be; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_be = be; a_req = 1'b1;
        end
        while (!done && n < 60) begin
            @(posedge clk); #1; n++;
            if (n == drop_at) begin
                if (is_b) b_req = 1'b0; else a_req = 1'b0;
            end
            if (n == 2) begin
                if (is_b) begin
                    b_we = ~we; b_addr = addr ^ 19'h5A5A5; b_wdata = ~wdata; b_be = ~be;
                end else begin
                    a_we = ~we; a_addr = addr ^ 19'h5A5A5; a_wdata = ~wdata; a_be = ~be;
                end
            end
            if (!s_we_n) o_we_low++;
            if (!s_oe_n) o_oe_low++;
            if (!s_ce_n) begin
                if (s_a !== addr) o_a_bad++;
                if (s_be_n !== ~be) o_be_bad++;
                if (we && s_d !== wdata) o_d_bad++;
            end
            my_ack  = is_b ? b_ack : a_ack;
            oth_ack = is_b ? a_ack : b_ack;
            if (oth_ack) o_other++;
            if (my_ack) begin
                o_acks++;
                if (o_ack_cycle < 0) begin
                    o_ack_cycle = n;
                    o_rdata = is_b ? b_rdata : a_rdata;
                end
                if (is_b) b_req = 1'b0; else a_req = 1'b0;
            end
            if (o_ack_cycle >= 0 && n == o_ack_cycle + 2) begin
                o_busy_after = busy;
                done = 1;
            end
        end
        if (is_b) b_req = 1'b0; else a_req = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (s_ce_n !== 1'b1) begin fails++; $display("FAIL rst_ce_n: got %b want 1", s_ce_n); end
        checks++; if (s_oe_n !== 1'b1) begin fails++; $display("FAIL rst_oe_n: got %b want 1", s_oe_n); end
        checks++; if (s_we_n !== 1'b1) begin fails++; $display("FAIL rst_we_n: got %b want 1", s_we_n); end
        checks++; if (s_be_n !== 2'b11) begin fails++; $display("FAIL rst_be_n: got %b want 11", s_be_n); end
        checks++; if (s_a !== 19'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", s_a); end
        checks++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b%b want 00", a_ack, b_ack); end
        checks++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin fails++; $display("FAIL rst_rdata: got %h %h want 0 0", a_rdata, b_rdata); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (x_ce_n !== 1'b1) begin fails++; $display("FAIL rst_ce_n_w15: got %b want 1", x_ce_n); end
        ref_rdata[0] = 16'h0;
        ref_rdata[1] = 16'h0;
    endtask

    task automatic test_write_readback();
        run_access(0, 1'b1, 19'h01234, 16'hBEEF, 2'b11, 0);
        checks++; if (o_ack_cycle != W + 2) begin fails++; $display("FAIL wr_ack_cycle: got %0d want %0d", o_ack_cycle, W + 2); end
        checks++; if (o_we_low != W) begin fails++; $display("FAIL wr_we_low: got %0d want %0d", o_we_low, W); end
        checks++; if (o_oe_low != 0) begin fails++; $display("FAIL wr_oe_low: got %0d want 0", o_oe_low); end
        checks++; if (o_d_bad != 0) begin fails++; $display("FAIL wr_data_bus: got %0d bad cycles want 0", o_d_bad); end
        checks++; if (o_a_bad != 0 || o_be_bad != 0) begin fails++; $display("FAIL wr_addr_be: got %0d/%0d bad want 0/0", o_a_bad, o_be_bad); end
        checks++; if (o_acks != 1) begin fails++; $display("FAIL wr_ack_count: got %0d want 1", o_acks); end
        checks++; if (o_busy_after !== 1'b0) begin fails++; $display("FAIL wr_busy_idle: got %b want 0", o_busy_after); end
        checks++; if (a_rdata !== ref_rdata[0]) begin fails++; $display("FAIL wr_rdata_kept: got %h want %h", a_rdata, ref_rdata[0]); end
        run_access(0, 1'b0, 19'h01234, 16'h0000, 2'b11, 0);
        checks++; if (o_rdata !== 16'hBEEF) begin fails++; $display("FAIL rd_back_data: got %h want BEEF", o_rdata); end
        checks++; if (o_oe_low != W) begin fails++; $display("FAIL rd_back_oe_low: got %0d want %0d", o_oe_low, W); end
        checks++; if (o_we_low != 0) begin fails++; $display("FAIL rd_back_we_low: got %0d want 0", o_we_low); end
        ref_rdata[0] = 16'hBEEF;
    endtask

    task automatic test_b_read();
        preload_idx = 12'h000; preload_val = 16'hA55A; preload_en = 1'b1;
        @(posedge clk); #1;
        preload_en = 1'b0;
        run_access(1, 1'b0, 19'h02000, 16'h1111, 2'b01, 0);
        checks++; if (o_rdata !== 16'hA55A) begin fails++; $display("FAIL brd_ack_data: got %h want A55A", o_rdata); end
        checks++; if (b_rdata !== 16'hA55A) begin fails++; $display("FAIL brd_rdata_hold: got %h want A55A", b_rdata); end
        checks++; if (o_be_bad != 0) begin fails++; $display("FAIL brd_be_n: got %0d bad cycles want 0", o_be_bad); end
        checks++; if (o_oe_low != W) begin fails++; $display("FAIL brd_oe_low: got %0d want %0d", o_oe_low, W); end
        checks++; if (o_we_low != 0) begin fails++; $display("FAIL brd_we_low: got %0d want 0", o_we_low); end
        checks++; if (o_ack_cycle != W + 2) begin fails++; $display("FAIL brd_ack_cycle: got %0d want %0d", o_ack_cycle, W + 2); end
        checks++; if (a_rdata !== ref_rdata[0]) begin fails++; $display("FAIL brd_a_rdata_kept: got %h want %h", a_rdata, ref_rdata[0]); end
        ref_rdata[1] = 16'hA55A;
    endtask

    task automatic test_contention();
        bit got_b [4];
        bit exp_b [4];
        bit last_b_m;
        int k, n;
        k = 0; n = 0;
        for (int i = 0; i < 4; i++) got_b[i] = 1'b0;
        a_we = 1'b1; a_addr = 19'h00200; a_wdata = 16'h0A0A; a_be = 2'b11;
        b_we = 1'b1; b_addr = 19'h00201; b_wdata = 16'h0B0B; b_be = 2'b11;
        a_req = 1'b1; b_req = 1'b1;
        while (k < 4 && n < 200) begin
            @(posedge clk); #1; n++;
            if (a_ack) begin got_b[k] = 1'b0; k++; end
            else if (b_ack) begin got_b[k] = 1'b1; k++; end
            if (k == 4) begin a_req = 1'b0; b_req = 1'b0; end
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Both always pending: apply the arbitration rule four times.
        last_b_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            exp_b[i] = !last_b_m;
`else
            exp_b[i] = 1'b0;
`endif
            last_b_m = exp_b[i];
        end
        checks++; if (k != 4) begin fails++; $display("FAIL cont_grants: got %0d grants want 4", k); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                fails++; $display("FAIL cont_grant_%0d: got %s want %s", i, got_b[i] ? "B" : "A", exp_b[i] ? "B" : "A");
            end
        end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL cont_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_drop_req();
        run_access(1, 1'b1, 19'h00300, 16'h5AA5, 2'b11, 1);
        checks++; if (o_acks != 1) begin fails++; $display("FAIL drop_ack_count: got %0d want 1", o_acks); end
        checks++; if (o_ack_cycle != W + 2) begin fails++; $display("FAIL drop_ack_cycle: got %0d want %0d", o_ack_cycle, W + 2); end
        checks++; if (o_we_low != W || o_d_bad != 0) begin fails++; $display("FAIL drop_write: got we_low %0d bad %0d want %0d 0", o_we_low, o_d_bad, W); end
        checks++; if (o_busy_after !== 1'b0) begin fails++; $display("FAIL drop_idle: got busy %b want 0", o_busy_after); end
        checks++; if (b_rdata !== ref_rdata[1]) begin fails++; $display("FAIL drop_rdata_kept: got %h want %h", b_rdata, ref_rdata[1]); end
    endtask

    task automatic test_wait15();
        int n, ack_cyc, a_bad, we_low, oe_low, d_bad, be_bad, other;
        logic busy_after;
        bit done;
        n = 0; ack_cyc = -1; a_bad = 0; we_low = 0; oe_low = 0; d_bad = 0; be_bad = 0; other = 0;
        busy_after = 1'bx; done = 0;
        x_we = 1'b1; x_addr = 19'h0ABCD; x_wdata = 16'h1357; x_be = 2'b11; x_req = 1'b1;
        while (!done && n < 60) begin
            @(posedge clk); #1; n++;
            if (n == 5) x_addr = 19'h7FFFF;
            if (!x_we_n) we_low++;
            if (!x_oe_n) oe_low++;
            if (!x_ce_n) begin
                if (x_sa !== 19'h0ABCD) a_bad++;
                if (x_sd !== 16'h1357) d_bad++;
                if (x_be_n !== 2'b00) be_bad++;
            end
            if (y_ack) other++;
            if (x_ack && ack_cyc < 0) begin ack_cyc = n; x_req = 1'b0; end
            if (ack_cyc >= 0 && n == ack_cyc + 2) begin busy_after = x_busy; done = 1; end
        end
        x_req = 1'b0;
        checks++; if (ack_cyc != W15 + 2) begin fails++; $display("FAIL w15_ack_cycle: got %0d want %0d", ack_cyc, W15 + 2); end
        checks++; if (a_bad != 0) begin fails++; $display("FAIL w15_addr_hold: got %0d bad cycles want 0", a_bad); end
        checks++; if (we_low != W15) begin fails++; $display("FAIL w15_we_low: got %0d want %0d", we_low, W15); end
        checks++; if (oe_low != 0 || d_bad != 0 || be_bad != 0) begin fails++; $display("FAIL w15_bus: got oe %0d d %0d be %0d want 0 0 0", oe_low, d_bad, be_bad); end
        checks++; if (other != 0) begin fails++; $display("FAIL w15_b_ack: got %0d want 0", other); end
        checks++; if (busy_after !== 1'b0) begin fails++; $display("FAIL w15_idle: got busy %b want 0", busy_after); end
        checks++; if (x_rdata !== 16'h0 || y_rdata !== 16'h0) begin fails++; $display("FAIL w15_rdata: got %h %h want 0 0", x_rdata, y_rdata); end
    endtask

    task automatic test_random();
        bit          is_b, we;
        int          idx;
        logic [18:0] addr;
        logic [15:0] wdata, exp;
        logic [1:0]  be;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
        for (int it = 0; it < 40; it++) begin
            is_b  = 1'($urandom % 2);
            we    = (it < 6) ? 1'b1 : 1'($urandom % 2);
            idx   = int'($urandom_range(0, 7));
            addr  = 19'h00100 + 19'(idx);
            wdata = 16'($urandom);
            be    = 2'($urandom_range(0, 3));
            run_access(is_b, we, addr, wdata, be, 0);
            checks++; if (o_ack_cycle != W + 2 || o_acks != 1 || o_other != 0) begin
                fails++; $display("FAIL rnd%0d_handshake: got cyc %0d acks %0d other %0d want %0d 1 0", it, o_ack_cycle, o_acks, o_other, W + 2);
            end
            checks++; if (o_a_bad != 0 || o_be_bad != 0) begin
                fails++; $display("FAIL rnd%0d_addr_be: got %0d/%0d bad want 0/0", it, o_a_bad, o_be_bad);
            end
            if (we) begin
                ref_mem[idx] = merge(ref_mem[idx], wdata, be);
                checks++; if (o_we_low != W || o_d_bad != 0 || o_oe_low != 0) begin
                    fails++; $display("FAIL rnd%0d_write: got we_low %0d bad %0d oe_low %0d want %0d 0 0", it, o_we_low, o_d_bad, o_oe_low, W);
                end
                checks++; if ((is_b ? b_rdata : a_rdata) !== ref_rdata[is_b]) begin
                    fails++; $display("FAIL rnd%0d_rdata_kept: got %h want %h", it, is_b ? b_rdata : a_rdata, ref_rdata[is_b]);
                end
            end else begin
                exp = ref_mem[idx];
                ref_rdata[is_b] = exp;
                checks++; if (o_rdata !== exp || o_oe_low != W || o_we_low != 0) begin
                    fails++; $display("FAIL rnd%0d_read: got %h oe_low %0d we_low %0d want %h %0d 0", it, o_rdata, o_oe_low, o_we_low, exp, W);
                end
            end
            checks++; if ((is_b ? a_rdata : b_rdata) !== ref_rdata[!is_b]) begin
                fails++; $display("FAIL rnd%0d_other_rdata: got %h want %h", it, is_b ? a_rdata : b_rdata, ref_rdata[!is_b]);
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        int acks;
        a_we = 1'b1; a_addr = 19'h03000; a_wdata = 16'hC0DE; a_be = 2'b11; a_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s_we_n !== 1'b0) begin fails++; $display("FAIL rms_in_strobe: got we_n %b want 0", s_we_n); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (s_we_n !== 1'b1 || s_ce_n !== 1'b1 || s_oe_n !== 1'b1) begin
            fails++; $display("FAIL rms_strobes: got we_n %b ce_n %b oe_n %b want 1 1 1", s_we_n, s_ce_n, s_oe_n);
        end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rms_busy: got %b want 0", busy); end
        checks++; if (s_be_n !== 2'b11 || s_a !== 19'h0) begin fails++; $display("FAIL rms_addr_be: got %h %b want 0 11", s_a, s_be_n); end
        checks++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin fails++; $display("FAIL rms_rdata: got %h %h want 0 0", a_rdata, b_rdata); end
        a_req = 1'b0;
        acks = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (n == 2) rst_n = 1'b1;
            if (a_ack || b_ack) acks++;
        end
        checks++; if (acks != 0) begin fails++; $display("FAIL rms_no_ack: got %0d acks want 0", acks); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rms_idle_after: got busy %b want 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        x_req = 1'b0; x_we = 1'b0; x_addr = '0; x_wdata = '0; x_be = '0;
        mem_clear = 1'b1; preload_en = 1'b0; preload_idx = '0; preload_val = '0;
        @(posedge clk); #1;
        mem_clear = 1'b0;
        @(posedge clk); #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_write_readback();
        test_b_read();
        test_contention();
        test_drop_req();
        test_wait15();
        test_random();
        test_reset_mid_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
